// File: rtl/nou_axi_slv_mem.sv
// AXI4 slave memory of MEM_DEPTH words, one transaction at a time, write/read alternating under contention.
// Reads present the first beat one cycle after AR; later beats follow each accepted beat with no bubble.
module nou_axi_slv_mem #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    nou_clk,
    input  logic                    nou_rstn,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IW     = ADDR_WIDTH - OFFS;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IW-1:0] DEPTH_IDX  = IW'(MEM_DEPTH);
    localparam logic [2:0]    FULL_SIZE  = 3'(OFFS);
    localparam logic [1:0]    RESP_OKAY  = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [1:0]    BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t                 state_q;
    logic                   last_wr_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [IW-1:0]          idx_q;
    logic [7:0]             len_q;
    logic [7:0]             beat_q;
    logic                   fixed_q;
    logic                   bad_q;
    logic                   err_q;
    logic                   bvalid_q;
    logic [ID_WIDTH-1:0]    bid_q;
    logic [1:0]             bresp_q;
    logic                   rvalid_q;
    logic                   rlast_q;
    logic [ID_WIDTH-1:0]    rid_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [1:0]             rresp_q;

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic                   wr_gnt, rd_gnt;
    logic                   aw_bad, ar_bad;
    logic [IW-1:0]          aw_idx, ar_idx;
    logic                   w_last, w_oob, w_beat_err, mem_we;
    logic [IW-1:0]          nxt_idx_d;
    logic                   rd_err_d;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic                   unused_ok;

    // Under contention the direction not granted last time wins; the flag resets to "read last".
    assign wr_gnt = s_axi_awvalid && (!s_axi_arvalid || !last_wr_q);
    assign rd_gnt = s_axi_arvalid && (!s_axi_awvalid || last_wr_q);

    assign s_axi_awready = nou_rstn && (state_q == IDLE) && wr_gnt;
    assign s_axi_arready = nou_rstn && (state_q == IDLE) && rd_gnt;
    assign s_axi_wready  = (state_q == WR_DATA);
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    assign aw_idx = s_axi_awaddr[ADDR_WIDTH-1:OFFS];
    assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:OFFS];
    assign aw_bad = s_axi_awburst[1] || (s_axi_awsize != FULL_SIZE);
    assign ar_bad = s_axi_arburst[1] || (s_axi_arsize != FULL_SIZE);

    assign w_last     = (beat_q == len_q);
    assign w_oob      = (idx_q >= DEPTH_IDX);
    assign w_beat_err = w_oob || (s_axi_wlast != w_last);
    assign mem_we     = nou_rstn && (state_q == WR_DATA) && s_axi_wvalid && !bad_q && !w_oob;

    // Index of the next beat; in IDLE it is the first beat of an incoming read.
    always_comb begin
        nxt_idx_d = fixed_q ? idx_q : (idx_q + IW'(1));
        rd_err_d  = bad_q;
        if (state_q == IDLE) begin
            nxt_idx_d = ar_idx;
            rd_err_d  = ar_bad;
        end
        rd_err_d = rd_err_d || (nxt_idx_d >= DEPTH_IDX);
        rd_word  = mem[nxt_idx_d[MEM_AW-1:0]];
    end

    always_ff @(posedge nou_clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[idx_q[MEM_AW-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge nou_clk) begin
        if (!nou_rstn) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            id_q      <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            fixed_q   <= 1'b0;
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_axi_awready) begin
                        id_q      <= s_axi_awid;
                        idx_q     <= aw_idx;
                        len_q     <= s_axi_awlen;
                        fixed_q   <= (s_axi_awburst == BURST_FIXED);
                        bad_q     <= aw_bad;
                        beat_q    <= '0;
                        err_q     <= 1'b0;
                        last_wr_q <= 1'b1;
                        state_q   <= WR_DATA;
                    end else if (s_axi_arready) begin
                        id_q      <= s_axi_arid;
                        idx_q     <= ar_idx;
                        len_q     <= s_axi_arlen;
                        fixed_q   <= (s_axi_arburst == BURST_FIXED);
                        bad_q     <= ar_bad;
                        beat_q    <= '0;
                        err_q     <= 1'b0;
                        last_wr_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= s_axi_arid;
                        rdata_q   <= rd_err_d ? '0 : rd_word;
                        rresp_q   <= rd_err_d ? RESP_SLVERR : RESP_OKAY;
                        rlast_q   <= (s_axi_arlen == 8'd0);
                        state_q   <= RD_DATA;
                    end
                end
                WR_DATA: begin
                    if (s_axi_wvalid) begin
                        beat_q <= beat_q + 8'd1;
                        idx_q  <= nxt_idx_d;
                        if (w_beat_err) begin
                            err_q <= 1'b1;
                        end
                        if (w_last) begin
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= (bad_q || err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state_q  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (s_axi_rready) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            idx_q   <= nxt_idx_d;
                            rdata_q <= rd_err_d ? '0 : rd_word;
                            rresp_q <= rd_err_d ? RESP_SLVERR : RESP_OKAY;
                            rlast_q <= ((beat_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign unused_ok = ^{s_axi_awaddr[OFFS-1:0], s_axi_araddr[OFFS-1:0],
                         s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

endmodule

// File: tb/tb_nou_axi_slv_mem.sv
// Scoreboard bench for nou_axi_slv_mem: a reference memory predicts B responses and R beats.
module tb_nou_axi_slv_mem;

    logic         nou_clk;
    logic         nou_rstn;
    logic [3:0]   awid, arid, bid, rid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awvalid, awready, arvalid, arready;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;
    logic         wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

    nou_axi_slv_mem dut (
        .nou_clk(nou_clk), .nou_rstn(nou_rstn),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
        .s_axi_awqos(4'd0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arqos(4'd0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    typedef struct {
        logic [3:0]   id;
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } rbeat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bresp_t;

    rbeat_t       rq[$];
    bresp_t       bq[$];
    logic [127:0] ref_mem [256];
    logic [127:0] wbuf [16];
    logic [15:0]  sbuf [16];
    int           n_vec  = 0;
    int           n_miss = 0;

    initial nou_clk = 1'b0;
    always #5 nou_clk = ~nou_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge nou_clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_awready"}, 128'(awready), 128'(0));
        check_val({tag, "_arready"}, 128'(arready), 128'(0));
        check_val({tag, "_wready"},  128'(wready),  128'(0));
        check_val({tag, "_bvalid"},  128'(bvalid),  128'(0));
        check_val({tag, "_rvalid"},  128'(rvalid),  128'(0));
        check_val({tag, "_rlast"},   128'(rlast),   128'(0));
        check_val({tag, "_bid"},     128'(bid),     128'(0));
        check_val({tag, "_bresp"},   128'(bresp),   128'(0));
        check_val({tag, "_rid"},     128'(rid),     128'(0));
        check_val({tag, "_rresp"},   128'(rresp),   128'(0));
        check_val({tag, "_rdata"},   rdata,         128'(0));
    endtask

    // Uses wbuf/sbuf as beat data; abort_beat >= 0 pulls reset while that beat is offered.
    task automatic axi_wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input int abort_beat, input bit bad_last);
        bit     bad, oob;
        int     t, widx;
        bresp_t be;
        bad = burst[1] || (size != 3'd4);
        oob = 1'b0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        #1;
        t = 0;
        while (!awready && t < 20) begin step(); t++; end
        if (t >= 20) begin
            check_val("aw_timeout", 128'(0), 128'(1));
            awvalid = 1'b0;
            return;
        end
        step();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = sbuf[i]; wvalid = 1'b1;
            wlast = bad_last ? (i == 0) : (i == int'(len));
            if (i == abort_beat) begin
                nou_rstn = 1'b0;
                step();
                wvalid = 1'b0; wlast = 1'b0;
                return;
            end
            #1;
            check_val("wready", 128'(wready), 128'(1));
            step();
            widx = (burst == 2'b00) ? int'(addr >> 4) : int'(addr >> 4) + i;
            if (widx >= 256) oob = 1'b1;
            else if (!bad && !bad_last) begin
                for (int b = 0; b < 16; b++)
                    if (sbuf[i][b]) ref_mem[widx][b*8 +: 8] = wbuf[i][b*8 +: 8];
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        check_val("wready_drop", 128'(wready), 128'(0));
        bq.push_back('{id: id, resp: (bad || oob || bad_last) ? 2'b10 : 2'b00});
        bready = 1'b1;
        t = 0;
        #1;
        while (!bvalid && t < 20) begin step(); t++; end
        if (t >= 20) begin
            check_val("b_timeout", 128'(0), 128'(1));
            bq.delete();
        end else begin
            be = bq.pop_front();
            check_val("bid",   128'(bid),   128'(be.id));
            check_val("bresp", 128'(bresp), 128'(be.resp));
            check_val("b_no_accept", 128'({awready, arready}), 128'(0));
            step();
        end
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [7:0] rpat);
        bit           bad, stalled, err;
        int           t, k, idx;
        logic [127:0] held;
        rbeat_t       e;
        bad = burst[1] || (size != 3'd4);
        for (int i = 0; i <= int'(len); i++) begin
            idx = (burst == 2'b00) ? int'(addr >> 4) : int'(addr >> 4) + i;
            err = bad || (idx >= 256);
            rq.push_back('{id: id, data: err ? 128'(0) : ref_mem[idx],
                           resp: err ? 2'b10 : 2'b00, last: (i == int'(len))});
        end
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        #1;
        t = 0;
        while (!arready && t < 20) begin step(); t++; end
        if (t >= 20) begin
            check_val("ar_timeout", 128'(0), 128'(1));
            arvalid = 1'b0;
            rq.delete();
            return;
        end
        step();
        arvalid = 1'b0;
        check_val("rvalid_lat", 128'(rvalid), 128'(1));
        k = 0; stalled = 1'b0; held = '0;
        while (rq.size() > 0 && k < 200) begin
            rready = rpat[k % 8];
            #1;
            if (stalled) check_val("rhold", rdata, held);
            if (rvalid && rready) begin
                e = rq.pop_front();
                check_val("rid",   128'(rid),   128'(e.id));
                check_val("rdata", rdata,       e.data);
                check_val("rresp", 128'(rresp), 128'(e.resp));
                check_val("rlast", 128'(rlast), 128'(e.last));
                stalled = 1'b0;
            end else if (rvalid) begin
                stalled = 1'b1;
                held = rdata;
            end else begin
                check_val("rvalid_bubble", 128'(rvalid), 128'(1));
            end
            step();
            k++;
        end
        if (rq.size() > 0) begin
            check_val("r_timeout", 128'(rq.size()), 128'(0));
            rq.delete();
        end
        rready = 1'b0;
        check_val("rvalid_drop", 128'(rvalid), 128'(0));
    endtask

    initial begin
        nou_rstn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd4; awburst = 2'b01; awvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        repeat (3) step();
        check_reset_outputs("rst");
        nou_rstn = 1'b1;
        step();

        // Simultaneous AW/AR right after reset: write first, then read.
        for (int i = 0; i < 4; i++) begin wbuf[i] = rnd128(); sbuf[i] = 16'hFFFF; end
        arid = 4'd3; araddr = 32'h40; arlen = 8'd3; arburst = 2'b01; arsize = 3'd4; arvalid = 1'b1;
        awid = 4'd3; awaddr = 32'h40; awlen = 8'd3; awburst = 2'b01; awsize = 3'd4; awvalid = 1'b1;
        #1;
        check_val("gnt1_aw", 128'(awready), 128'(1));
        check_val("gnt1_ar", 128'(arready), 128'(0));
        axi_wr(4'd3, 32'h40, 8'd3, 2'b01, 3'd4, -1, 1'b0);
        awvalid = 1'b1;
        #1;
        check_val("gnt2_ar", 128'(arready), 128'(1));
        check_val("gnt2_aw", 128'(awready), 128'(0));
        awvalid = 1'b0;
        axi_rd(4'd3, 32'h40, 8'd3, 2'b01, 3'd4, 8'hFF);

        // Byte strobes on word 5, including an all-zero strobe.
        wbuf[0] = {128{1'b1}}; sbuf[0] = 16'hFFFF;
        axi_wr(4'd1, 32'h50, 8'd0, 2'b01, 3'd4, -1, 1'b0);
        wbuf[0] = '0; sbuf[0] = 16'h0001;
        axi_wr(4'd1, 32'h50, 8'd0, 2'b01, 3'd4, -1, 1'b0);
        wbuf[0] = rnd128(); sbuf[0] = 16'h0000;
        axi_wr(4'd2, 32'h50, 8'd0, 2'b01, 3'd4, -1, 1'b0);
        axi_rd(4'd2, 32'h50, 8'd0, 2'b01, 3'd4, 8'hFF);

        // Burst running off the top of memory.
        for (int i = 0; i < 2; i++) begin wbuf[i] = rnd128(); sbuf[i] = 16'hFFFF; end
        axi_wr(4'd4, 32'd254 * 16, 8'd1, 2'b01, 3'd4, -1, 1'b0);
        axi_rd(4'd5, 32'd254 * 16, 8'd3, 2'b01, 3'd4, 8'hFF);

        // Stalled read, WRAP write rejection, FIXED burst, bad size, bad wlast.
        for (int i = 0; i < 4; i++) begin wbuf[i] = rnd128(); sbuf[i] = 16'hFFFF; end
        axi_wr(4'd6, 32'h80, 8'd3, 2'b01, 3'd4, -1, 1'b0);
        axi_rd(4'd7, 32'h80, 8'd3, 2'b01, 3'd4, 8'b1111_1001);
        for (int i = 0; i < 4; i++) wbuf[i] = rnd128();
        axi_wr(4'd8, 32'h50, 8'd3, 2'b10, 3'd4, -1, 1'b0);
        axi_rd(4'd8, 32'h50, 8'd0, 2'b01, 3'd4, 8'hFF);
        axi_rd(4'd9, 32'h80, 8'd2, 2'b00, 3'd4, 8'b1010_1010);
        axi_rd(4'd10, 32'h80, 8'd0, 2'b01, 3'd3, 8'hFF);
        for (int i = 0; i < 2; i++) wbuf[i] = rnd128();
        axi_wr(4'd11, 32'h1E0, 8'd1, 2'b01, 3'd4, -1, 1'b1);

        // Reset during beat 2 of a write, then a normal read of the beats that landed.
        for (int i = 0; i < 4; i++) begin wbuf[i] = rnd128(); sbuf[i] = 16'hFFFF; end
        axi_wr(4'd12, 32'h140, 8'd3, 2'b01, 3'd4, 2, 1'b0);
        #1;
        check_reset_outputs("midrst");
        nou_rstn = 1'b1;
        step();
        axi_rd(4'd13, 32'h140, 8'd1, 2'b01, 3'd4, 8'hFF);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
